// File: rtl/i2s_tx_master.sv
// I2S / left-justified / TDM master transmitter.
// Divides adc_clk down to bclk, generates wclk and shifts NUM_CH samples per
// frame out MSB-first. Samples come in through a one-frame holding buffer.
module i2s_tx_master #(
  parameter int CLK_DIV  = 2,
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int MODE     = 0
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0]   s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         i2s_bclk,
  output logic                         i2s_wclk,
  output logic                         i2s_sdata,
  output logic                         underrun
);

  localparam int FRAME  = NUM_CH * SLOT_W;
  localparam int HALF   = FRAME / 2;
  localparam int F_W    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DATA_W = NUM_CH * SAMPLE_W;
  localparam int IDX_W  = $clog2(DATA_W);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              bclk_q, bclk_d;
  logic              wclk_q, wclk_d;
  logic              sdata_q, sdata_d;
  logic [F_W-1:0]    f_q, f_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              underrun_q, underrun_d;

  logic              tick, fall, wrap, boundary, accept;
  logic [F_W-1:0]    f_nxt;
  logic [IDX_W-1:0]  bit_idx;
  int                fi, slot_c, slot_b;

  // Handshake: a transfer happens on a cycle where s_valid && s_ready; s_ready
  // is high exactly when the holding buffer is empty and does not depend on s_valid.
  assign s_ready   = !buf_full_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_wclk  = wclk_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

  // Next-state: divider, frame index, slot bit selection, buffer handshake.
  always_comb begin
    tick     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    fall     = tick && bclk_q;
    wrap     = (f_q == F_W'(FRAME - 1));
    boundary = fall && wrap;
    accept   = s_valid && !buf_full_q;
    f_nxt    = wrap ? '0 : f_q + 1'b1;

    // Slot/bit coordinates of the frame position that the next fall event enters.
    fi      = int'(f_nxt);
    slot_c  = fi / SLOT_W;
    slot_b  = fi % SLOT_W;
    bit_idx = '0;

    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    bclk_d     = tick ? ~bclk_q : bclk_q;
    f_d        = f_q;
    wclk_d     = wclk_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    underrun_d = boundary && !buf_full_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;

    // The boundary samples the buffer state before any same-cycle accept lands.
    if (boundary) begin
      shift_d = buf_full_q ? buf_q : '0;
    end

    if (fall) begin
      f_d = f_nxt;
      if (MODE == 1) begin
        wclk_d = (fi >= HALF);
      end else begin
        wclk_d = (((fi + 1) % FRAME) >= HALF);
      end
      if (slot_b < SAMPLE_W) begin
        bit_idx = IDX_W'(slot_c * SAMPLE_W + SAMPLE_W - 1 - slot_b);
        sdata_d = shift_d[bit_idx];
      end else begin
        sdata_d = 1'b0;
      end
    end

    if (accept) begin
      buf_d      = s_data;
      buf_full_d = 1'b1;
    end else if (boundary) begin
      buf_full_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      wclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      f_q        <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      wclk_q     <= wclk_d;
      sdata_q    <= sdata_d;
      f_q        <= f_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: default I2S, left-justified and 8-channel
// TDM instances, driven one scenario task at a time.
module tb_i2s_tx_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [47:0]  s_data0, s_data1;
  logic [127:0] s_data2;
  logic         s_valid0, s_valid1, s_valid2;
  logic         s_ready0, s_ready1, s_ready2;
  logic         bclk0, bclk1, bclk2;
  logic         wclk0, wclk1, wclk2;
  logic         sdata0, sdata1, sdata2;
  logic         ur0, ur1, ur2;

  i2s_tx_master dut0 (
    .adc_clk(clk), .rst_n(rst_n), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
    .i2s_bclk(bclk0), .i2s_wclk(wclk0), .i2s_sdata(sdata0), .underrun(ur0)
  );

  i2s_tx_master #(.MODE(1)) dut1 (
    .adc_clk(clk), .rst_n(rst_n), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .i2s_bclk(bclk1), .i2s_wclk(wclk1), .i2s_sdata(sdata1), .underrun(ur1)
  );

  i2s_tx_master #(.CLK_DIV(1), .NUM_CH(8), .SAMPLE_W(16), .MODE(1)) dut2 (
    .adc_clk(clk), .rst_n(rst_n), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .i2s_bclk(bclk2), .i2s_wclk(wclk2), .i2s_sdata(sdata2), .underrun(ur2)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          sel      = 0;
  logic [511:0] cap_bits, cap_w;
  int          ur_cnt;
  bit          cap_ok;
  bit          cap_done;
  logic [47:0] exp_q[$];

  logic ob_bclk, ob_wclk, ob_sdata, ob_ur;

  // Route the selected instance to the capture monitor.
  always_comb begin
    case (sel)
      1:       begin ob_bclk = bclk1; ob_wclk = wclk1; ob_sdata = sdata1; ob_ur = ur1; end
      2:       begin ob_bclk = bclk2; ob_wclk = wclk2; ob_sdata = sdata2; ob_ur = ur2; end
      default: begin ob_bclk = bclk0; ob_wclk = wclk0; ob_sdata = sdata0; ob_ur = ur0; end
    endcase
  end

  // ---------------- driver / monitor tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    s_valid0 = 1'b0; s_valid1 = 1'b0; s_valid2 = 1'b0;
    s_data0 = '0; s_data1 = '0; s_data2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sync on a wclk falling edge, optionally skip one bclk rise, then record
  // sdata/wclk at each following bclk rise. Counts underrun pulses throughout.
  task automatic capture(input int nbits, input bit skip_one);
    int   guard;
    int   n;
    bit   skip;
    logic pw, pb;
    cap_bits = '0; cap_w = '0; ur_cnt = 0; n = 0; guard = 0; cap_ok = 1'b0;
    skip = skip_one;
    pw = ob_wclk;
    while (guard < 5000) begin
      @(negedge clk);
      guard++;
      if (ob_ur) ur_cnt++;
      if (pw && !ob_wclk) break;
      pw = ob_wclk;
    end
    if (guard >= 5000) return;
    pb = ob_bclk;
    while (n < nbits && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (ob_ur) ur_cnt++;
      if (!pb && ob_bclk) begin
        if (skip) skip = 1'b0;
        else begin
          cap_bits[n] = ob_sdata;
          cap_w[n]    = ob_wclk;
          n++;
        end
      end
      pb = ob_bclk;
    end
    cap_ok = (n == nbits);
  endtask

  function automatic logic [31:0] slot_word(input int base, input int width);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < width; b++) w = {w[30:0], cap_bits[base + b]};
    return w;
  endfunction

  function automatic logic [47:0] bp_pat(input int k);
    return {24'h500000 + 24'(k), 24'hA00000 + 24'(k)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (bclk0 !== 1'b0) begin n_fail++; $display("FAIL rst_bclk: got %b expected 0", bclk0); end
    n_checks++; if (wclk0 !== 1'b0) begin n_fail++; $display("FAIL rst_wclk: got %b expected 0", wclk0); end
    n_checks++; if (sdata0 !== 1'b0) begin n_fail++; $display("FAIL rst_sdata: got %b expected 0", sdata0); end
    n_checks++; if (ur0 !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b expected 0", ur0); end
    n_checks++; if (bclk2 !== 1'b0) begin n_fail++; $display("FAIL rst_bclk_tdm: got %b expected 0", bclk2); end
    @(negedge clk);
    n_checks++; if (s_ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", s_ready0); end
    n_checks++; if (s_ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_ready_lj: got %b expected 1", s_ready1); end
    n_checks++; if (s_ready2 !== 1'b1) begin n_fail++; $display("FAIL rst_ready_tdm: got %b expected 1", s_ready2); end
    n_checks++; if (bclk0 !== 1'b0) begin n_fail++; $display("FAIL rst_bclk_c1: got %b expected 0", bclk0); end
  endtask

  task automatic test_defaults();
    int first_b, last_b, b_bad, w_r1, w_r2, ur1, ur2, ur_n, sd_n;
    logic pb, pw;
    do_reset();
    first_b = -1; last_b = 0; b_bad = 0; w_r1 = -1; w_r2 = -1;
    ur1 = -1; ur2 = -1; ur_n = 0; sd_n = 0;
    pb = bclk0; pw = wclk0;
    for (int t = 1; t <= 600; t++) begin
      @(negedge clk);
      if (!pb && bclk0) begin
        if (first_b < 0) first_b = t;
        else if (t - last_b != 4) b_bad++;
        last_b = t;
      end
      if (!pw && wclk0) begin
        if (w_r1 < 0) w_r1 = t;
        else if (w_r2 < 0) w_r2 = t;
      end
      if (ur0) begin
        ur_n++;
        if (ur1 < 0) ur1 = t;
        else if (ur2 < 0) ur2 = t;
      end
      if (sdata0) sd_n++;
      pb = bclk0; pw = wclk0;
    end
    n_checks++; if (first_b !== 2) begin n_fail++; $display("FAIL def_first_bclk: got %0d expected 2", first_b); end
    n_checks++; if (b_bad !== 0) begin n_fail++; $display("FAIL def_bclk_period: got %0d bad periods expected 0", b_bad); end
    n_checks++; if (w_r1 !== 124) begin n_fail++; $display("FAIL def_wclk_rise1: got %0d expected 124", w_r1); end
    n_checks++; if (w_r2 !== 380) begin n_fail++; $display("FAIL def_wclk_rise2: got %0d expected 380", w_r2); end
    n_checks++; if (ur1 !== 256) begin n_fail++; $display("FAIL def_underrun1: got %0d expected 256", ur1); end
    n_checks++; if (ur2 !== 512) begin n_fail++; $display("FAIL def_underrun2: got %0d expected 512", ur2); end
    n_checks++; if (ur_n !== 2) begin n_fail++; $display("FAIL def_underrun_cnt: got %0d expected 2", ur_n); end
    n_checks++; if (sd_n !== 0) begin n_fail++; $display("FAIL def_sdata_silent: got %0d ones expected 0", sd_n); end
  endtask

  task automatic test_i2s();
    logic [63:0] exp_w;
    do_reset();
    sel = 0;
    s_data0 = {24'h123456, 24'hABCDEF};
    s_valid0 = 1'b1;
    @(negedge clk);
    s_valid0 = 1'b0;
    s_data0 = {$urandom, $urandom};
    n_checks++; if (s_ready0 !== 1'b0) begin n_fail++; $display("FAIL i2s_ready_drop: got %b expected 0", s_ready0); end
    capture(64, 1'b1);
    for (int i = 0; i < 64; i++) exp_w[i] = (((i + 1) % 64) >= 32);
    n_checks++; if (cap_ok !== 1'b1) begin n_fail++; $display("FAIL i2s_capture_timeout: got %b expected 1", cap_ok); end
    n_checks++; if (cap_bits[0] !== 1'b1) begin n_fail++; $display("FAIL i2s_msb: got %b expected 1", cap_bits[0]); end
    n_checks++; if (slot_word(0, 24) !== 32'hABCDEF) begin n_fail++; $display("FAIL i2s_left: got %h expected abcdef", slot_word(0, 24)); end
    n_checks++; if (slot_word(24, 8) !== 32'h0) begin n_fail++; $display("FAIL i2s_left_pad: got %h expected 0", slot_word(24, 8)); end
    n_checks++; if (slot_word(32, 24) !== 32'h123456) begin n_fail++; $display("FAIL i2s_right: got %h expected 123456", slot_word(32, 24)); end
    n_checks++; if (slot_word(56, 8) !== 32'h0) begin n_fail++; $display("FAIL i2s_right_pad: got %h expected 0", slot_word(56, 8)); end
    n_checks++; if (cap_w[63:0] !== exp_w) begin n_fail++; $display("FAIL i2s_wclk_align: got %h expected %h", cap_w[63:0], exp_w); end
    n_checks++; if (ur_cnt !== 0) begin n_fail++; $display("FAIL i2s_underrun: got %0d expected 0", ur_cnt); end
  endtask

  task automatic test_lj();
    logic [63:0] exp_w;
    do_reset();
    sel = 1;
    s_data1 = {24'h123456, 24'hABCDEF};
    s_valid1 = 1'b1;
    @(negedge clk);
    s_valid1 = 1'b0;
    s_data1 = '0;
    capture(64, 1'b0);
    for (int i = 0; i < 64; i++) exp_w[i] = (i >= 32);
    n_checks++; if (cap_ok !== 1'b1) begin n_fail++; $display("FAIL lj_capture_timeout: got %b expected 1", cap_ok); end
    n_checks++; if (slot_word(0, 24) !== 32'hABCDEF) begin n_fail++; $display("FAIL lj_left: got %h expected abcdef", slot_word(0, 24)); end
    n_checks++; if (slot_word(24, 8) !== 32'h0) begin n_fail++; $display("FAIL lj_left_pad: got %h expected 0", slot_word(24, 8)); end
    n_checks++; if (slot_word(32, 24) !== 32'h123456) begin n_fail++; $display("FAIL lj_right: got %h expected 123456", slot_word(32, 24)); end
    n_checks++; if (cap_w[63:0] !== exp_w) begin n_fail++; $display("FAIL lj_wclk_align: got %h expected %h", cap_w[63:0], exp_w); end
    n_checks++; if (ur_cnt !== 0) begin n_fail++; $display("FAIL lj_underrun: got %0d expected 0", ur_cnt); end
  endtask

  task automatic test_back_to_back();
    int k;
    int accepts;
    bit pend;
    logic [47:0] e;
    do_reset();
    sel = 0;
    exp_q.delete();
    cap_done = 1'b0;
    k = 0; accepts = 0; pend = 1'b0;
    s_data0 = bp_pat(0);
    s_valid0 = 1'b1;
    fork
      begin
        while (!cap_done) begin
          if (s_ready0) begin exp_q.push_back(s_data0); accepts++; pend = 1'b1; end
          @(negedge clk);
          if (pend) begin
            n_checks++; if (s_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b expected 0", s_ready0); end
            k++;
            s_data0 = bp_pat(k);
            pend = 1'b0;
          end
        end
      end
      begin
        capture(192, 1'b1);
        cap_done = 1'b1;
      end
    join
    s_valid0 = 1'b0;
    n_checks++; if (cap_ok !== 1'b1) begin n_fail++; $display("FAIL bp_capture_timeout: got %b expected 1", cap_ok); end
    n_checks++; if (accepts !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 4", accepts); end
    n_checks++; if (ur_cnt !== 0) begin n_fail++; $display("FAIL bp_underrun: got %0d expected 0", ur_cnt); end
    for (int fr = 0; fr < 3; fr++) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL bp_queue_empty: got 0 entries expected frame %0d", fr);
      end else begin
        e = exp_q.pop_front();
        n_checks++; if (slot_word(fr * 64, 24) !== {8'h0, e[23:0]}) begin n_fail++; $display("FAIL bp_frame%0d_left: got %h expected %h", fr, slot_word(fr * 64, 24), e[23:0]); end
        n_checks++; if (slot_word(fr * 64 + 32, 24) !== {8'h0, e[47:24]}) begin n_fail++; $display("FAIL bp_frame%0d_right: got %h expected %h", fr, slot_word(fr * 64 + 32, 24), e[47:24]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel = 0;
    s_data0 = {24'h7FFFFF, 24'hFFFFFF};
    s_valid0 = 1'b1;
    @(negedge clk);
    s_valid0 = 1'b0;
    repeat (159) @(negedge clk);
    n_checks++; if (s_ready0 !== 1'b0) begin n_fail++; $display("FAIL mid_ready_before: got %b expected 0", s_ready0); end
    n_checks++; if (wclk0 !== 1'b1) begin n_fail++; $display("FAIL mid_wclk_before: got %b expected 1", wclk0); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bclk0 !== 1'b0) begin n_fail++; $display("FAIL mid_bclk: got %b expected 0", bclk0); end
    n_checks++; if (wclk0 !== 1'b0) begin n_fail++; $display("FAIL mid_wclk: got %b expected 0", wclk0); end
    n_checks++; if (sdata0 !== 1'b0) begin n_fail++; $display("FAIL mid_sdata: got %b expected 0", sdata0); end
    n_checks++; if (ur0 !== 1'b0) begin n_fail++; $display("FAIL mid_underrun: got %b expected 0", ur0); end
    n_checks++; if (s_ready0 !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", s_ready0); end
    rst_n = 1'b1;
    capture(128, 1'b1);
    n_checks++; if (cap_ok !== 1'b1) begin n_fail++; $display("FAIL mid_capture_timeout: got %b expected 1", cap_ok); end
    n_checks++; if (cap_bits[127:0] !== 128'h0) begin n_fail++; $display("FAIL mid_discarded: got %h expected 0", cap_bits[127:0]); end
    n_checks++; if (ur_cnt !== 2) begin n_fail++; $display("FAIL mid_underrun_cnt: got %0d expected 2", ur_cnt); end
  endtask

  task automatic test_tdm();
    logic [255:0] exp_w;
    logic [15:0]  smp;
    int r1, r2;
    logic pb;
    do_reset();
    sel = 2;
    for (int c = 0; c < 8; c++) s_data2[c*16 +: 16] = 16'h8001 + 16'(c) * 16'h1111;
    s_valid2 = 1'b1;
    @(negedge clk);
    s_valid2 = 1'b0;
    r1 = -1; r2 = -1;
    pb = bclk2;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (!pb && bclk2) begin
        if (r1 < 0) r1 = t;
        else if (r2 < 0) r2 = t;
      end
      pb = bclk2;
    end
    n_checks++; if (r2 - r1 !== 2) begin n_fail++; $display("FAIL tdm_bclk_period: got %0d expected 2", r2 - r1); end
    capture(256, 1'b0);
    for (int i = 0; i < 256; i++) exp_w[i] = (i >= 128);
    n_checks++; if (cap_ok !== 1'b1) begin n_fail++; $display("FAIL tdm_capture_timeout: got %b expected 1", cap_ok); end
    n_checks++; if (cap_w[255:0] !== exp_w) begin n_fail++; $display("FAIL tdm_wclk: got %h expected %h", cap_w[255:0], exp_w); end
    for (int c = 0; c < 8; c++) begin
      smp = 16'h8001 + 16'(c) * 16'h1111;
      n_checks++; if (slot_word(c * 32, 16) !== {16'h0, smp}) begin n_fail++; $display("FAIL tdm_ch%0d: got %h expected %h", c, slot_word(c * 32, 16), smp); end
      n_checks++; if (slot_word(c * 32 + 16, 16) !== 32'h0) begin n_fail++; $display("FAIL tdm_ch%0d_pad: got %h expected 0", c, slot_word(c * 32 + 16, 16)); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_i2s();
    test_lj();
    test_back_to_back();
    test_reset_mid();
    test_tdm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
